mult_div_unit: RTL

- E-stage multiply/divide unit of the five-stage MIPS pipeline with CP0/interrupt support.
- Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, and MTHI/MTLO in a single cycle.
- Holds architectural HI/LO and drives MFHI/MFLO read data back into the E-stage result mux.
- Produces `busy` and echoes `start`; the hazard unit uses these to stall any D-stage mult/div-class instruction while an operation is in flight.

---
 rtl/md_pkg.sv | 25 ++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MDOp codes,
// default latencies and the IDLE/BUSY state encoding.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit holding architectural HI/LO. The result is computed
// at launch and parked in pending registers until the busy window expires.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        start_o,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pwe_q, pwe_d;

  logic idle, launch, wr_en, is_mul;
  assign idle    = (state_q == ST_IDLE);
  assign start_o = start & ~req & is_launch_op(MDOp);
  assign launch  = start_o & idle;
  assign wr_en   = start & ~req & idle;
  assign is_mul  = (MDOp == MD_MULT) || (MDOp == MD_MULTU);

  // Products: low 64 bits of the sign/zero-extended operands give the exact result.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  logic        sgn;
  logic [31:0] ua, ub, uq, ur, q, r;
  assign sgn = (MDOp == MD_DIV);
  assign ua  = (sgn && A[31]) ? (32'd0 - A) : A;
  assign ub  = (sgn && B[31]) ? (32'd0 - B) : B;
  assign uq  = (ub != 32'd0) ? (ua / ub) : 32'd0;
  assign ur  = (ub != 32'd0) ? (ua % ub) : 32'd0;
  assign q   = (sgn && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
  assign r   = (sgn && A[31]) ? (32'd0 - ur) : ur;

  logic [31:0] res_hi, res_lo;
  logic        res_we;
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    case (MDOp)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_hi = r;
        res_lo = q;
        res_we = (B != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwe_d   = pwe_q;
    if (launch) begin
      state_d = ST_BUSY;
      cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      phi_d   = res_hi;
      plo_d   = res_lo;
      pwe_d   = res_we;
    end else if (wr_en && MDOp == MD_MTHI) begin
      hi_d = A;
    end else if (wr_en && MDOp == MD_MTLO) begin
      lo_d = A;
    end
    if (state_q == ST_BUSY) begin
      if (cnt_q <= CW'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (pwe_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwe_q   <= pwe_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = (MDOp == MD_MFHI) ? hi_q : (MDOp == MD_MFLO) ? lo_q : 32'd0;

endmodule
